riscv_muldiv: RTL and testbench

RISCV_MULDIV -- requirements
Module: riscv_muldiv

---
 rtl/riscv_muldiv.sv | 141 ++++++++++++++
 tb/tb_riscv_muldiv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on magnitudes.
// Define RISCV_MULDIV_FAST_MUL_EN to route MUL/MULH/MULHSU/MULHU through a single-cycle multiplier.
module riscv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_rs1, r_rs2, r_result;
  logic [2*XLEN-1:0] r_prod;
  logic [CW-1:0]     r_cnt;

  // Decode of the latched operation
  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg, w_last;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_opnd, w_rem_quo, w_final;
  logic [2*XLEN-1:0] w_cur, w_prod_next, w_prod_signed;
  logic [XLEN:0]   w_sum, w_shift, w_diff;

  assign w_is_div   = r_funct3[2];
  assign w_a_signed = w_is_div ? ~r_funct3[0] : (r_funct3[1:0] == 2'd1 || r_funct3[1:0] == 2'd2);
  assign w_b_signed = w_is_div ? ~r_funct3[0] : (r_funct3[1:0] == 2'd1);
  assign w_a_neg    = w_a_signed & r_rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & r_rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -r_rs1 : r_rs1;
  assign w_b_mag    = w_b_neg ? -r_rs2 : r_rs2;
  // Remainder takes the dividend's sign; quotients and products take the XOR
  assign w_neg      = (w_is_div & r_funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_opnd     = w_is_div ? w_b_mag : w_a_mag;
  assign w_last     = (r_cnt == CW'(XLEN - 1));

  // First iteration seeds the working register straight from the latched operands
  assign w_cur   = (r_cnt == '0) ? {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)} : r_prod;
  assign w_sum   = {1'b0, w_cur[2*XLEN-1:XLEN]} + (w_cur[0] ? {1'b0, w_opnd} : '0);
  assign w_shift = w_cur[2*XLEN-1:XLEN-1];
  assign w_diff  = w_shift - {1'b0, w_opnd};

  always_comb begin
    w_prod_next = w_cur;
    if (!w_is_div)
      w_prod_next = {w_sum, w_cur[XLEN-1:1]};
    else if (!w_diff[XLEN])
      w_prod_next = {w_diff[XLEN-1:0], w_cur[XLEN-2:0], 1'b1};
    else
      w_prod_next = {w_shift[XLEN-1:0], w_cur[XLEN-2:0], 1'b0};
  end

  assign w_prod_signed = w_neg ? -w_prod_next : w_prod_next;
  assign w_rem_quo     = r_funct3[1] ? w_prod_next[2*XLEN-1:XLEN] : w_prod_next[XLEN-1:0];
  assign w_final       = w_is_div ? (w_neg ? -w_rem_quo : w_rem_quo)
                       : ((r_funct3[1:0] == 2'd0) ? w_prod_signed[XLEN-1:0]
                                                  : w_prod_signed[2*XLEN-1:XLEN]);

  // Requests that complete at the accepting edge
  logic            w_div0, w_ovf, w_fast_mul, w_skip;
  logic [XLEN-1:0] w_fast_res, w_skip_res;

  assign w_div0 = funct3[2] && (rs2 == '0);
  assign w_ovf  = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (&rs2);

`ifdef RISCV_MULDIV_FAST_MUL_EN
  logic              w_in_a_s, w_in_b_s;
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_in_a_s    = (funct3[1:0] == 2'd1) || (funct3[1:0] == 2'd2);
  assign w_in_b_s    = (funct3[1:0] == 2'd1);
  assign w_fast_prod = {{XLEN{w_in_a_s & rs1[XLEN-1]}}, rs1} * {{XLEN{w_in_b_s & rs2[XLEN-1]}}, rs2};
  assign w_fast_mul  = ~funct3[2];
  assign w_fast_res  = (funct3[1:0] == 2'd0) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast_mul  = 1'b0;
  assign w_fast_res  = '0;
`endif

  assign w_skip     = w_div0 | w_ovf | w_fast_mul;
  assign w_skip_res = w_div0 ? (funct3[1] ? rs1 : '1)
                    : w_ovf ? (funct3[1] ? '0 : rs1)
                    : w_fast_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush)
      w_state_next = S_IDLE;
    else if (!stall) begin
      case (r_state)
        S_IDLE:  if (in_valid) w_state_next = w_skip ? S_DONE : S_CALC;
        S_CALC:  if (w_last) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!flush && !stall) begin
      if (r_state == S_IDLE && in_valid) begin
        r_funct3 <= funct3;
        r_rs1    <= rs1;
        r_rs2    <= rs2;
        r_cnt    <= '0;
        if (w_skip) r_result <= w_skip_res;
      end else if (r_state == S_CALC) begin
        r_prod <= w_prod_next;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) r_result <= w_final;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv (XLEN=32) with an expected-result queue.
module tb_riscv_muldiv;
  localparam int XLEN = 32;

  logic        clk, reset, stall, flush, in_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, out_valid;
  logic [31:0] result;

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_edge;
  bit          busy_gap;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  riscv_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .busy(busy), .out_valid(out_valid), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model built on native 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic [63:0] p;
    logic [31:0] r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'b0, b};
    r   = '0;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0];  end
      3'd1: begin p = sa * sb;                 r = p[63:32]; end
      3'd2: begin p = sa * sbu;                r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
      return 1;
`else
      return XLEN + 1;
`endif
    end
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3   = f;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    exp_q.push_back(model(f, a, b));
    tick();
    in_valid = 1'b0;
    n_edge   = 1;
    busy_gap = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int lat);
    while (!out_valid && n_edge < 100) begin
      if (!busy) busy_gap = 1'b1;
      tick();
      n_edge++;
    end
    chk({tag, " latency"}, 64'(n_edge), 64'(lat));
    chk({tag, " busy"}, 64'(busy_gap), 64'd0);
    last_exp = exp_q.pop_front();
    chk({tag, " result"}, 64'(result), 64'(last_exp));
    $display("op %s f=%0d rs1=%h rs2=%h result=%h latency=%0d", tag, funct3, rs1, rs2, result, n_edge);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    start(f, a, b);
    finish_op(tag, exp_lat(f, a, b));
    tick();
    chk({tag, " idle"}, 64'({busy, out_valid}), 64'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          seen;

    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    reset = 1'b0;
    tick();

    run(3'd0, 32'd7,          32'hFFFF_FFFD, "mul");
    run(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu");
    run(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulh");
    run(3'd2, 32'hFFFF_FFFF,  32'd2,         "mulhsu");
    run(3'd4, 32'hFFFF_FFF9,  32'd2,         "div");
    run(3'd6, 32'hFFFF_FFF9,  32'd2,         "rem");
    run(3'd5, 32'd100,        32'd7,         "divu");
    run(3'd7, 32'd100,        32'd7,         "remu");
    run(3'd5, 32'd5,          32'd0,         "divu_by0");
    run(3'd6, 32'd5,          32'd0,         "rem_by0");
    run(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
    run(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");

    // Request while busy is dropped, not queued
    start(3'd5, 32'd100, 32'd7);
    repeat (3) begin tick(); n_edge++; end
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; in_valid = 1'b1;
    tick(); n_edge++;
    in_valid = 1'b0;
    finish_op("divu_busy", XLEN + 1);
    tick();
    seen = 0;
    repeat (40) begin if (out_valid || busy) seen++; tick(); end
    chk("no_queue", 64'(seen), 64'd0);

    // Flush mid-divide, then an immediate new request
    start(3'd4, 32'hFFFF_FFF9, 32'd2);
    while (n_edge < 10) begin tick(); n_edge++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush state", 64'({busy, out_valid}), 64'd0);
    chk("flush result", 64'(result), 64'(last_exp));
    void'(exp_q.pop_back());
    run(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_after_flush");

    // flush together with in_valid accepts nothing
    funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (3) begin if (busy || out_valid) seen++; tick(); end
    chk("flush_accept", 64'(seen), 64'd0);

    // Stall in CALC stretches latency; stall in DONE holds out_valid
    start(3'd5, 32'd100, 32'd7);
    while (n_edge < 10) begin tick(); n_edge++; end
    stall = 1'b1;
    repeat (5) begin tick(); n_edge++; end
    stall = 1'b0;
    finish_op("divu_stall", XLEN + 1 + 5);
    stall = 1'b1;
    seen = out_valid ? 1 : 0;
    repeat (3) begin
      tick();
      if (out_valid && result === last_exp) seen++;
    end
    stall = 1'b0;
    tick();
    chk("stall_done cycles", 64'(seen), 64'd4);
    chk("stall_done exit", 64'({busy, out_valid}), 64'd0);

    // Asynchronous reset mid-CALC
    start(3'd4, 32'h1234_5678, 32'd3);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("reset_async", 64'({busy, out_valid, result}), 64'd0);
    void'(exp_q.pop_back());
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (40) begin tick(); if (out_valid) seen++; end
    chk("reset_abandon", 64'(seen), 64'd0);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_post_reset");

    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = b >> 20;
      if (i % 4 == 3) b = '0;
      run(f, a, b, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
